// File: rtl/rom_burst_reader.sv
// Burst sequencer for a 1-cycle-latency ROM, streaming words out through a 2-entry FIFO.
// Optional build macro ROM_READ_CHECKSUM_EN adds csum_o, the XOR of the beats accepted in the current burst.
module rom_burst_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
`ifdef ROM_READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              inflight_q, inflight_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic              fifo_last_q [2];
  logic              fifo_last_d [2];
`ifdef ROM_READ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic       pop;
  logic       rom_en;
  logic [2:0] occ;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
`ifdef ROM_READ_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    pop = (cnt_q != 2'd0) && m_ready_i;
    // Slots already committed (stored + in flight) once this cycle's pop is accounted for.
    occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rom_en = (state_q == ST_BUSY) && (issued_q < len_q) && (occ < 3'd2);
    inflight_d = rom_en;

    rom_en_o   = rom_en;
    rom_addr_o = rom_en ? (base_q + ADDR_W'(issued_q)) : '0;

    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = rom_data_i;
      fifo_last_d[wr_ptr_q] = (wr_cnt_q == (len_q - LEN_ONE));
      wr_ptr_d              = ~wr_ptr_q;
      wr_cnt_d              = wr_cnt_q + LEN_ONE;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
`ifdef ROM_READ_CHECKSUM_EN
      csum_d   = csum_q ^ fifo_data_q[rd_ptr_q];
`endif
    end
    case ({inflight_q, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d   = base_i;
          len_d    = len_i;
          issued_d = '0;
          wr_cnt_d = '0;
`ifdef ROM_READ_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = (len_i != '0) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (rom_en) begin
          issued_d = issued_q + LEN_ONE;
          if ((issued_q + LEN_ONE) == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    m_valid_o = (cnt_q != 2'd0);
    m_data_o  = m_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    m_last_o  = m_valid_o && fifo_last_q[rd_ptr_q];
    busy_o    = (state_q != ST_IDLE);
    done_o    = (state_q == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
`ifdef ROM_READ_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
`ifdef ROM_READ_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; the outputs are gated by cnt_q, so stale entries are never seen.
  always_ff @(posedge clk_pi) begin
    fifo_data_q <= fifo_data_d;
    fifo_last_q <= fifo_last_d;
  end

`ifdef ROM_READ_CHECKSUM_EN
  assign csum_o = csum_q;
`endif

  // The issue rule must keep the FIFO from ever being written while full without a pop.
  a_no_overflow: assert property (@(posedge clk_pi) disable iff (rst_pi)
    !(inflight_q && (cnt_q == 2'd2) && !pop));

endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomized scoreboard bench for rom_burst_reader with a behavioural ROM and burst model.
module tb_rom_burst_reader;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic              clk_pi = 1'b0;
  logic              rst_pi;
  logic              start_i;
  logic [ADDR_W-1:0] base_i;
  logic [LEN_W-1:0]  len_i;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i = '0;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic              busy_o;
  logic              done_o;
`ifdef ROM_READ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_o;
`endif

  always #5 clk_pi = ~clk_pi;

  rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_pi     (clk_pi),
    .rst_pi     (rst_pi),
    .start_i    (start_i),
    .base_i     (base_i),
    .len_i      (len_i),
    .rom_en_o   (rom_en_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef ROM_READ_CHECKSUM_EN
    ,
    .csum_o     (csum_o)
`endif
  );

  // Behavioural single-port ROM: registered read, one cycle after en.
  logic [DATA_W-1:0] rom_img [8];
  initial rom_img = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd6, 8'd9};
  always @(posedge clk_pi) if (rom_en_o) rom_data_i <= rom_img[rom_addr_o];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             beat_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int                checks   = 0;
  int                failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1 repeating, 2 = random.
  int         ready_mode = 0;
  int         pat_idx    = 0;
  logic [3:0] ready_pat  = 4'b1001;
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk_pi);
      #1;
      case (ready_mode)
        0:       m_ready_i = 1'b1;
        1:       begin m_ready_i = ready_pat[pat_idx[1:0]]; pat_idx++; end
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / reference model, sampled mid-cycle on the falling edge.
  logic              model_active = 1'b0;
  logic              done_exp     = 1'b0;
  logic              done_next;
  logic              rst_prev     = 1'b0;
  logic              stall_prev   = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic              stall_last;
  logic [DATA_W-1:0] model_csum   = '0;
  int                outstanding  = 0;

  always @(negedge clk_pi) begin
    if (rst_pi) begin
      beat_q.delete();
      addr_q.delete();
      model_active = 1'b0;
      done_exp     = 1'b0;
      stall_prev   = 1'b0;
      outstanding  = 0;
      model_csum   = '0;
      rst_prev     = 1'b1;
    end else begin
      automatic logic pop = m_valid_o && m_ready_i;
      done_next = 1'b0;
      if (rst_prev) begin
        check("reset_outputs",
              {rom_en_o, rom_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o}, '0);
`ifdef ROM_READ_CHECKSUM_EN
        check("reset_csum", csum_o, '0);
`endif
      end
      rst_prev = 1'b0;

      check("busy", busy_o, model_active);
      if (done_o || done_exp) check("done", done_o, done_exp);
`ifdef ROM_READ_CHECKSUM_EN
      if (done_exp) check("csum", csum_o, model_csum);
`endif
      if (stall_prev)
        check("stall_stable", {m_valid_o, m_data_o, m_last_o}, {1'b1, stall_data, stall_last});

      if (rom_en_o) begin
        check("outstanding_le2", (outstanding - int'(pop)) < 2, 1);
        if (addr_q.size() == 0) begin
          check("unexpected_rom_en", rom_en_o, 1'b0);
        end else begin
          check("rom_addr", rom_addr_o, addr_q.pop_front());
        end
        outstanding++;
      end else begin
        check("rom_addr_idle", rom_addr_o, '0);
      end

      if (pop) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", m_valid_o, 1'b0);
        end else begin
          automatic beat_t exp_b = beat_q.pop_front();
          check("m_data", m_data_o, exp_b.data);
          check("m_last", m_last_o, exp_b.last);
          model_csum = model_csum ^ exp_b.data;
          if (exp_b.last) done_next = 1'b1;
        end
        outstanding--;
      end

      stall_prev = m_valid_o && !m_ready_i;
      stall_data = m_data_o;
      stall_last = m_last_o;

      if (start_i && !model_active) begin
        model_active = 1'b1;
        model_csum   = '0;
        for (int i = 0; i < int'(len_i); i++) begin
          automatic int a = (int'(base_i) + i) % 8;
          addr_q.push_back(ADDR_W'(a));
          beat_q.push_back('{data: rom_img[a], last: (i == int'(len_i) - 1)});
        end
        if (len_i == '0) done_next = 1'b1;
      end
      if (done_exp) model_active = 1'b0;
      done_exp = done_next;
    end
  end

  task automatic start_burst(input int b, input int l);
    start_i = 1'b1;
    base_i  = ADDR_W'(b);
    len_i   = LEN_W'(l);
    @(posedge clk_pi);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_o !== 1'b1 && n < 300) begin
      @(posedge clk_pi);
      #1;
      n++;
    end
    check("done_seen", done_o, 1'b1);
    @(posedge clk_pi);
    #1;
  endtask

  task automatic run_burst(input int b, input int l);
    start_burst(b, l);
    wait_done();
  endtask

  initial begin
    rst_pi  = 1'b1;
    start_i = 1'b0;
    base_i  = '0;
    len_i   = '0;
    repeat (3) @(posedge clk_pi);
    #1;
    rst_pi = 1'b0;
    @(posedge clk_pi);
    #1;

    ready_mode = 0;
    run_burst(1, 4);
    run_burst(6, 4);
    ready_mode = 1;
    run_burst(0, 8);
    ready_mode = 0;
    run_burst(0, 0);

    // Reset in the middle of a burst, then a short burst must return only its own word.
    start_burst(2, 6);
    repeat (3) @(posedge clk_pi);
    #1;
    rst_pi = 1'b1;
    @(posedge clk_pi);
    #1;
    rst_pi = 1'b0;
    @(posedge clk_pi);
    #1;
    run_burst(3, 1);

    // A second start while busy must be ignored.
    start_burst(0, 4);
    start_burst(5, 9);
    wait_done();

    ready_mode = 2;
    for (int k = 0; k < 20; k++) run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    ready_mode = 0;
    run_burst(7, 15);

    repeat (4) @(posedge clk_pi);
    #1;
    check("beats_drained", beat_q.size(), 0);
    check("addrs_drained", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
